// File: rtl/rename_controller.sv
// rename_controller
//   Register-rename stage between fetch/microcode and issue. It decodes up to
//   two architectural destinations per microop, pops fresh physical registers
//   from a 32-entry circular free list, updates the RAT (arch regs 2..11), and
//   presents the renamed microop through a one-deep output register.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_microop   microop handshake from fetch/microcode
//   out_valid/out_ready            renamed-microop handshake to issue
//   out_microop                    registered copy of the accepted microop
//   out_dest_regs                  new physical destinations (slot 0 low)
//   out_old_regs                   previous aliases, freed later at retire
//   out_dest_valid                 per-slot allocation flag
//   rat_done/rat_aliases           RAT state for arch 2..11 (index arch-2)
//   wb_valid/wb_reg                writeback: mark physical reg ready
//   free_valid/free_reg            retire: return physical reg to free list
//
// Configuration
//   RENAME_WB_BYPASS_EN  when defined, rat_done also shows same-cycle
//                        writeback hits; otherwise they appear a cycle later.

`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif

module rename_controller (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [23:0]               in_microop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [23:0]               out_microop,
    output logic [2*`PR_ADDR_W-1:0]   out_dest_regs,
    output logic [2*`PR_ADDR_W-1:0]   out_old_regs,
    output logic [1:0]                out_dest_valid,
    output logic [9:0]                rat_done,
    output logic [`PR_ADDR_W*10-1:0]  rat_aliases,
    input  logic                      wb_valid,
    input  logic [`PR_ADDR_W-1:0]     wb_reg,
    input  logic                      free_valid,
    input  logic [`PR_ADDR_W-1:0]     free_reg
);

    localparam int unsigned PW       = `PR_ADDR_W;
    localparam int unsigned FL_DEPTH = 32;
    localparam int unsigned RAT_N    = 10;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    // ---------------- decode ----------------
    logic [3:0] opcode, arch0, arch1;
    logic       has0, has1, alloc0, alloc1;
    logic [1:0] need;

    always_comb begin
        opcode = in_microop[23:20];
        arch0  = in_microop[15:12];
        arch1  = in_microop[19:16];
        has0   = (opcode <= 4'd12);
        has1   = (opcode <= 4'd11);
        // Only arch 2..11 have RAT entries; anything else is not renamed.
        alloc1 = has1 && (arch1 >= 4'd2) && (arch1 <= 4'd11);
        alloc0 = has0 && (arch0 >= 4'd2) && (arch0 <= 4'd11) &&
                 !(alloc1 && (arch0 == arch1));
        need   = {1'b0, alloc0} + {1'b0, alloc1};
    end

    // ---------------- state ----------------
    logic [PW-1:0] fl_mem [FL_DEPTH];
    logic [4:0]    fl_head, fl_tail;
    logic [5:0]    fl_count;

    logic [PW-1:0] alias_q [RAT_N];
    logic [9:0]    done_q;

    out_state_t    out_state, out_state_nxt;

    logic          xfer, push;
    logic [1:0]    pop_n;
    logic [PW-1:0] new0, new1, old0, old1;
    logic [9:0]    wb_hit;

    always_comb begin
        out_valid = (out_state == OUT_FULL);
        in_ready  = !rst && ({4'b0, need} <= fl_count) && (!out_valid || out_ready);
        xfer      = in_valid && in_ready;
        pop_n     = xfer ? need : 2'd0;
        // A push at full is dropped; registers 0/1 are never renamed targets.
        push      = free_valid && (free_reg >= PW'(2)) && (fl_count != 6'd32);
        // Slot 0 pops first, so slot 1 takes the next entry only if slot 0 popped.
        new0      = fl_mem[fl_head];
        new1      = alloc0 ? fl_mem[fl_head + 5'd1] : fl_mem[fl_head];
    end

    always_comb begin
        old0   = '0;
        old1   = '0;
        wb_hit = '0;
        for (int unsigned i = 0; i < RAT_N; i++) begin
            if (alloc0 && (arch0 == 4'(i + 2))) old0 = alias_q[i];
            if (alloc1 && (arch1 == 4'(i + 2))) old1 = alias_q[i];
            wb_hit[i] = !rst && wb_valid && (alias_q[i] == wb_reg);
        end
    end

    // ---------------- free list ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // Entries 12..31 hold their own index, so head=12/tail=0 gives 12..31.
            for (int unsigned i = 0; i < FL_DEPTH; i++) fl_mem[i] <= PW'(i);
            fl_head  <= 5'd12;
            fl_tail  <= '0;
            fl_count <= 6'd20;
        end else begin
            if (push) begin
                fl_mem[fl_tail] <= free_reg;
                fl_tail         <= fl_tail + 5'd1;
            end
            fl_head  <= fl_head + {3'b0, pop_n};
            fl_count <= fl_count + {5'b0, push} - {4'b0, pop_n};
        end
    end

    // ---------------- RAT ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RAT_N; i++) alias_q[i] <= PW'(i + 2);
            done_q <= '1;
        end else begin
            for (int unsigned i = 0; i < RAT_N; i++) begin
                if (wb_hit[i]) done_q[i] <= 1'b1;
                // Later assignments win: a rename overrides a same-cycle writeback.
                if (xfer && alloc0 && (arch0 == 4'(i + 2))) begin
                    alias_q[i] <= new0;
                    done_q[i]  <= 1'b0;
                end
                if (xfer && alloc1 && (arch1 == 4'(i + 2))) begin
                    alias_q[i] <= new1;
                    done_q[i]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rat_aliases = '0;
        for (int unsigned i = 0; i < RAT_N; i++) rat_aliases[i*PW +: PW] = alias_q[i];
`ifdef RENAME_WB_BYPASS_EN
        rat_done = done_q | wb_hit;
`else
        rat_done = done_q;
`endif
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (rst) out_state <= OUT_EMPTY;
        else     out_state <= out_state_nxt;
    end

    always_comb begin
        out_state_nxt = out_state;
        if (xfer)
            out_state_nxt = OUT_FULL;
        else if ((out_state == OUT_FULL) && out_ready)
            out_state_nxt = OUT_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_microop    <= '0;
            out_dest_regs  <= '0;
            out_old_regs   <= '0;
            out_dest_valid <= '0;
        end else if (xfer) begin
            out_microop    <= in_microop;
            out_dest_regs  <= {alloc1 ? new1 : PW'(0), alloc0 ? new0 : PW'(0)};
            out_old_regs   <= {old1, old0};
            out_dest_valid <= {alloc1, alloc0};
        end
    end

endmodule
